// File: rtl/rat_flag_intr_unit_pkg.sv
// Shared types and constants for the RAT flag / interrupt stage.
package rat_flags_pkg;

  typedef enum logic [1:0] {
    C_HOLD = 2'b00,
    C_LOAD = 2'b01,
    C_SET  = 2'b10,
    C_CLR  = 2'b11
  } flg_c_op_t;

  localparam logic C_RST_VAL = 1'b0;
  localparam logic Z_RST_VAL = 1'b0;
  localparam logic I_RST_VAL = 1'b0;

  localparam int DEF_INTR_SYNC_STAGES = 2;

endpackage

// File: rtl/rat_flag_intr_unit_if.sv
// Control-unit <-> flag/interrupt stage signal bundle.
interface rat_flag_intr_unit_if;
  logic       ALU_C;
  logic       ALU_Z;
  logic [1:0] FLG_C_OP;
  logic       FLG_Z_LD;
  logic       FLG_RESTORE;
  logic       I_SET;
  logic       I_CLR;
  logic       INTR;
  logic       INT_ACK;
  logic       C_FLAG;
  logic       Z_FLAG;
  logic       I_FLAG;
  logic       INT_REQ;

  modport master (
    output ALU_C, ALU_Z, FLG_C_OP, FLG_Z_LD, FLG_RESTORE, I_SET, I_CLR, INTR, INT_ACK,
    input  C_FLAG, Z_FLAG, I_FLAG, INT_REQ
  );

  modport slave (
    input  ALU_C, ALU_Z, FLG_C_OP, FLG_Z_LD, FLG_RESTORE, I_SET, I_CLR, INTR, INT_ACK,
    output C_FLAG, Z_FLAG, I_FLAG, INT_REQ
  );
endinterface

// File: rtl/rat_flag_intr_unit_intr_latch.sv
// INTR synchronizer, rising-edge detector and pending latch.
module rat_intr_latch
  import rat_flags_pkg::*;
#(
  parameter int INTR_SYNC_STAGES = DEF_INTR_SYNC_STAGES
) (
  input  logic CLK,
  input  logic RST,
  input  logic INTR,
  input  logic INT_ACK,
  output logic PENDING
);

  logic [INTR_SYNC_STAGES-1:0] sync_q;
  logic [INTR_SYNC_STAGES-1:0] sync_d;
  logic                        prev_q;
  logic                        pending_q;
  logic                        pending_d;
  logic                        intr_s;
  logic                        rise;

  assign sync_d = {sync_q[INTR_SYNC_STAGES-2:0], INTR};
  assign intr_s = sync_q[INTR_SYNC_STAGES-1];
  assign rise   = intr_s & ~prev_q;

  // A fresh edge beats a coincident acknowledge so no event is dropped.
  assign pending_d = rise | (pending_q & ~INT_ACK);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= intr_s;
      pending_q <= pending_d;
    end
  end

  assign PENDING = pending_q;

endmodule

// File: rtl/rat_flag_intr_unit.sv
// Architectural C/Z/I flags, interrupt shadow and request generation.
// Optional shadow/restore path is built when RAT_FLAG_SHADOW_EN is defined.
module rat_flag_intr_unit
  import rat_flags_pkg::*;
#(
  parameter int INTR_SYNC_STAGES = DEF_INTR_SYNC_STAGES
) (
  input  logic               CLK,
  input  logic               RST,
  rat_flag_intr_unit_if.slave bus
);

  logic c_q, c_d;
  logic z_q, z_d;
  logic i_q, i_d;
  logic pending;

`ifdef RAT_FLAG_SHADOW_EN
  logic sh_c_q;
  logic sh_z_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_c_q <= 1'b0;
      sh_z_q <= 1'b0;
    end else if (bus.INT_ACK) begin
      sh_c_q <= c_q;
      sh_z_q <= z_q;
    end
  end
`else
  logic unused_restore;
  assign unused_restore = bus.FLG_RESTORE;
`endif

  always_comb begin
    c_d = c_q;
    z_d = z_q;
    // Interrupt entry freezes C/Z so the shadow captures a stable pair.
    if (!bus.INT_ACK) begin
`ifdef RAT_FLAG_SHADOW_EN
      if (bus.FLG_RESTORE) begin
        c_d = sh_c_q;
        z_d = sh_z_q;
      end else
`endif
      begin
        case (flg_c_op_t'(bus.FLG_C_OP))
          C_LOAD:  c_d = bus.ALU_C;
          C_SET:   c_d = 1'b1;
          C_CLR:   c_d = 1'b0;
          default: c_d = c_q;
        endcase
        if (bus.FLG_Z_LD) begin
          z_d = bus.ALU_Z;
        end
      end
    end
  end

  always_comb begin
    i_d = i_q;
    if (bus.INT_ACK || bus.I_CLR) begin
      i_d = 1'b0;
    end else if (bus.I_SET) begin
      i_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c_q <= C_RST_VAL;
      z_q <= Z_RST_VAL;
      i_q <= I_RST_VAL;
    end else begin
      c_q <= c_d;
      z_q <= z_d;
      i_q <= i_d;
    end
  end

  rat_intr_latch #(
    .INTR_SYNC_STAGES(INTR_SYNC_STAGES)
  ) u_latch (
    .CLK    (CLK),
    .RST    (RST),
    .INTR   (bus.INTR),
    .INT_ACK(bus.INT_ACK),
    .PENDING(pending)
  );

  assign bus.C_FLAG  = c_q;
  assign bus.Z_FLAG  = z_q;
  assign bus.I_FLAG  = i_q;
  assign bus.INT_REQ = pending & i_q;

endmodule

// File: tb/tb_rat_flag_intr_unit.sv
// Self-checking bench for rat_flag_intr_unit: vector table, corner sequences, random vs model.
module tb_rat_flag_intr_unit;
  import rat_flags_pkg::*;

  localparam int S = DEF_INTR_SYNC_STAGES;
`ifdef RAT_FLAG_SHADOW_EN
  localparam bit SHADOW_EN = 1'b1;
`else
  localparam bit SHADOW_EN = 1'b0;
`endif

  typedef struct {
    bit       alu_c;
    bit       alu_z;
    bit [1:0] c_op;
    bit       z_ld;
    bit       restore;
    bit       i_set;
    bit       i_clr;
    bit       intr;
    bit       ack;
  } in_t;

  typedef struct {
    in_t in;
    bit  exp_c;
    bit  exp_z;
    bit  exp_i;
    bit  exp_req;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  rat_flag_intr_unit_if bus ();

  rat_flag_intr_unit #(.INTR_SYNC_STAGES(S)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Reference state: architectural flags, shadow, pending event and INTR history.
  bit m_c, m_z, m_i, m_sc, m_sz, m_pend;
  bit hist[$];

  function automatic bit m_req();
    return m_pend & m_i;
  endfunction

  task automatic model_reset();
    m_c = 0; m_z = 0; m_i = 0; m_sc = 0; m_sz = 0; m_pend = 0;
    hist.delete();
  endtask

  // An edge at clock n is detected S clocks after INTR was first sampled high.
  task automatic model_edge(input in_t v);
    int n;
    bit cur, prv, rise;
    hist.push_back(v.intr);
    if (hist.size() > S + 4) void'(hist.pop_front());
    n   = hist.size() - 1;
    cur = (n - S >= 0) ? hist[n - S] : 1'b0;
    prv = (n - S - 1 >= 0) ? hist[n - S - 1] : 1'b0;
    rise = cur & ~prv;
    if (v.ack) begin
      m_sc = m_c;
      m_sz = m_z;
    end else if (SHADOW_EN && v.restore) begin
      m_c = m_sc;
      m_z = m_sz;
    end else begin
      if (v.c_op == 2'b01) m_c = v.alu_c;
      else if (v.c_op == 2'b10) m_c = 1'b1;
      else if (v.c_op == 2'b11) m_c = 1'b0;
      if (v.z_ld) m_z = v.alu_z;
    end
    if (v.ack || v.i_clr) m_i = 1'b0;
    else if (v.i_set) m_i = 1'b1;
    m_pend = rise | (m_pend & ~v.ack);
  endtask

  task automatic check(input string name, input logic act, input bit exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s txn=%0d actual=%0b required=%0b", name, txn, act, exp);
    end
  endtask

  task automatic check_model();
    check("c_flag", bus.C_FLAG, m_c);
    check("z_flag", bus.Z_FLAG, m_z);
    check("i_flag", bus.I_FLAG, m_i);
    check("int_req", bus.INT_REQ, m_req());
    check("pending", dut.u_latch.PENDING, m_pend);
  endtask

  task automatic step(input in_t v);
    bus.ALU_C       = v.alu_c;
    bus.ALU_Z       = v.alu_z;
    bus.FLG_C_OP    = v.c_op;
    bus.FLG_Z_LD    = v.z_ld;
    bus.FLG_RESTORE = v.restore;
    bus.I_SET       = v.i_set;
    bus.I_CLR       = v.i_clr;
    bus.INTR        = v.intr;
    bus.INT_ACK     = v.ack;
    if (v.ack) check("ack_legal", bus.INT_REQ, 1'b1);
    @(posedge CLK);
    if (RST) model_reset();
    else model_edge(v);
    #1;
    txn++;
    $display("txn %0d op=%0d zld=%0b rst=%0b set=%0b clr=%0b intr=%0b ack=%0b -> c=%0b z=%0b i=%0b req=%0b",
             txn, v.c_op, v.z_ld, v.restore, v.i_set, v.i_clr, v.intr, v.ack,
             bus.C_FLAG, bus.Z_FLAG, bus.I_FLAG, bus.INT_REQ);
    check_model();
  endtask

  vec_t tbl[10];
  in_t  v;
  in_t  z;

  initial begin
    #100000;
    $display("FAIL watchdog txn=%0d", txn);
    $fatal(1, "watchdog expired");
  end

  initial begin
    z = '{default: 0};
    // Flag command / I-priority table, applied straight out of reset.
    for (int k = 0; k < 10; k++) tbl[k] = '{in: z, exp_c: 0, exp_z: 0, exp_i: 0, exp_req: 0};
    tbl[0].in.alu_c = 1; tbl[0].in.c_op = 2'b01; tbl[0].in.z_ld = 1; tbl[0].exp_c = 1;
    tbl[1].in.alu_z = 1; tbl[1].in.c_op = 2'b11;
    tbl[2].in.c_op = 2'b10; tbl[2].exp_c = 1;
    tbl[3].in.alu_z = 1; tbl[3].in.z_ld = 1; tbl[3].exp_c = 1; tbl[3].exp_z = 1;
    tbl[4].in.i_set = 1; tbl[4].exp_c = 1; tbl[4].exp_z = 1; tbl[4].exp_i = 1;
    tbl[5].in.i_set = 1; tbl[5].in.i_clr = 1; tbl[5].exp_c = 1; tbl[5].exp_z = 1;
    tbl[6].in.i_set = 1; tbl[6].exp_c = 1; tbl[6].exp_z = 1; tbl[6].exp_i = 1;
    tbl[7].in.i_clr = 1; tbl[7].exp_c = 1; tbl[7].exp_z = 1;
    tbl[8].in.c_op = 2'b01; tbl[8].in.z_ld = 1;
    tbl[9].in.restore = 1; tbl[9].in.c_op = 2'b10; tbl[9].exp_c = SHADOW_EN ? 1'b0 : 1'b1;

    RST = 1'b1;
    bus.ALU_C = 0; bus.ALU_Z = 0; bus.FLG_C_OP = 2'b00; bus.FLG_Z_LD = 0;
    bus.FLG_RESTORE = 0; bus.I_SET = 0; bus.I_CLR = 0; bus.INTR = 0; bus.INT_ACK = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_c", bus.C_FLAG, 1'b0);
    check("reset_z", bus.Z_FLAG, 1'b0);
    check("reset_i", bus.I_FLAG, 1'b0);
    check("reset_req", bus.INT_REQ, 1'b0);
    #3 RST = 1'b0;

    for (int k = 0; k < 10; k++) begin
      step(tbl[k].in);
      check("tbl_c", bus.C_FLAG, tbl[k].exp_c);
      check("tbl_z", bus.Z_FLAG, tbl[k].exp_z);
      check("tbl_i", bus.I_FLAG, tbl[k].exp_i);
      check("tbl_req", bus.INT_REQ, tbl[k].exp_req);
    end

    // Interrupt entry and RETIE.
    v = z; v.c_op = 2'b10; v.z_ld = 1; v.alu_z = 1; v.i_set = 1; step(v);
    v = z; v.intr = 1; step(v);
    v = z;
    for (int k = 1; k < S; k++) step(v);
    check("req_early", bus.INT_REQ, 1'b0);
    step(v);
    check("req_rise", bus.INT_REQ, 1'b1);
    v = z; v.ack = 1; step(v);
    check("ack_req", bus.INT_REQ, 1'b0);
    check("ack_i", bus.I_FLAG, 1'b0);
    check("ack_c", bus.C_FLAG, 1'b1);
    check("ack_z", bus.Z_FLAG, 1'b1);
    v = z; v.c_op = 2'b11; v.z_ld = 1; step(v);
    v = z; v.restore = 1; v.i_set = 1; step(v);
    check("retie_c", bus.C_FLAG, SHADOW_EN);
    check("retie_z", bus.Z_FLAG, SHADOW_EN);
    check("retie_i", bus.I_FLAG, 1'b1);

    // Masked, held-high INTR gives exactly one request.
    v = z; v.i_clr = 1; step(v);
    v = z; v.intr = 1;
    repeat (10) step(v);
    check("masked_req", bus.INT_REQ, 1'b0);
    check("masked_pend", dut.u_latch.PENDING, 1'b1);
    v.i_set = 1; step(v);
    check("unmask_req", bus.INT_REQ, 1'b1);
    v = z; v.intr = 1; v.ack = 1; step(v);
    v = z; v.intr = 1; v.i_set = 1;
    for (int k = 0; k < 5; k++) begin
      step(v);
      check("held_no_req", bus.INT_REQ, 1'b0);
    end
    v = z; repeat (3) step(v);

    // New edge detected on the same clock as the acknowledge.
    for (int j = 0; j <= S + 2; j++) begin
      v = z;
      v.intr = (j == 0 || j == 2);
      v.ack  = (j == S + 2);
      step(v);
    end
    check("coinc_pend", dut.u_latch.PENDING, 1'b1);
    check("coinc_req", bus.INT_REQ, 1'b0);
    v = z; v.i_set = 1; step(v);
    check("coinc_rereq", bus.INT_REQ, 1'b1);
    v = z; v.ack = 1; step(v);
    v = z; repeat (S + 2) step(v);
    check("coinc_clear", dut.u_latch.PENDING, 1'b0);

    // Random traffic against the model.
    v = z;
    for (int k = 0; k < 400; k++) begin
      v.alu_c   = 1'($urandom_range(0, 1));
      v.alu_z   = 1'($urandom_range(0, 1));
      v.c_op    = 2'($urandom_range(0, 3));
      v.z_ld    = 1'($urandom_range(0, 1));
      v.restore = ($urandom_range(0, 7) == 0);
      v.i_set   = ($urandom_range(0, 3) == 0);
      v.i_clr   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) v.intr = ~v.intr;
      v.ack     = m_req() && ($urandom_range(0, 2) == 0);
      step(v);
    end

    // Asynchronous reset mid-cycle with everything set.
    v = z; v.c_op = 2'b10; v.z_ld = 1; v.alu_z = 1; v.i_set = 1; step(v);
    v = z; repeat (3) step(v);
    v = z; v.intr = 1; step(v);
    v = z; repeat (S) step(v);
    check("pre_rst_req", bus.INT_REQ, 1'b1);
    #3 RST = 1'b1;
    #1;
    model_reset();
    check("arst_c", bus.C_FLAG, 1'b0);
    check("arst_z", bus.Z_FLAG, 1'b0);
    check("arst_i", bus.I_FLAG, 1'b0);
    check("arst_req", bus.INT_REQ, 1'b0);
    check("arst_pend", dut.u_latch.PENDING, 1'b0);
    #2 RST = 1'b0;
    v = z; v.c_op = 2'b10; step(v);
    check("post_rst_c", bus.C_FLAG, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rat_flag_intr_unit.md
# rat_flag_intr_unit

Status-flag and interrupt-control stage directly downstream of the RAT ALU. Registers the ALU carry/zero outputs into the architectural C and Z flags under control-unit command. Shadows C/Z on interrupt entry and restores them on RETIE. Owns the interrupt-enable flag I and the edge-triggered pending-interrupt latch, and presents a level request/acknowledge handshake to the control unit.

## Interface
Parameters:
- `INTR_SYNC_STAGES`, default 2: synchronizer depth on `INTR`; legal values 2–3.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous and active-high.
- `ALU_C`  in  1  carry from ALU.
- `ALU_Z`  in  1  zero from ALU.
- `FLG_C_OP`  in  2  C command: 00 hold, 01 load `ALU_C`, 10 set, 11 clear.
- `FLG_Z_LD`  in  1  load `ALU_Z` into Z.
- `FLG_RESTORE`  in  1  restore C/Z from shadow (RETIE).
- `I_SET`  in  1  set I (SEI / RETIE).
- `I_CLR`  in  1  clear I (CLI).
- `INTR`  in  1  external interrupt, asynchronous level.
- `INT_ACK`  in  1  control unit accepting the interrupt (one-cycle strobe).
- `C_FLAG`  out  1  architectural carry.
- `Z_FLAG`  out  1  architectural zero.
- `I_FLAG`  out  1  interrupt enable.
- `INT_REQ`  out  1  interrupt request to control unit.

## Operation
- Reset values: `C_FLAG`=0, `Z_FLAG`=0, `I_FLAG`=0, shadow C/Z=0, pending=0, `INT_REQ`=0, synchronizer and edge-history flops=0.
- C update priority, highest first:
  - `INT_ACK`: C held.
  - `FLG_RESTORE`: C from shadow.
  - `FLG_C_OP`.
- Z update priority, highest first:
  - `INT_ACK`: Z held.
  - `FLG_RESTORE`: Z from shadow.
  - `FLG_Z_LD`.
- Shadow: loads current `C_FLAG`/`Z_FLAG` (pre-edge values) on `INT_ACK`. Otherwise holds.
- I update priority, highest first:
  - `INT_ACK`: clear.
  - `I_CLR`: clear.
  - `I_SET`: set.
  - Otherwise hold.
  - `I_SET` and `I_CLR` asserted together: result is cleared.
- Interrupt detect:
  - `INTR` passes through the synchronizer; the synchronized output is `intr_s`.
  - A rising edge (`intr_s`=1, previous=0) sets pending.
  - A held-high `INTR` produces exactly one pending event.
- Pending is cleared by `INT_ACK`. If a new edge is detected in the same cycle as `INT_ACK`, pending stays 1; set wins and the event is not lost.
- Pending is independent of I: edges arriving while I=0 are latched and requested once I=1.
- `INT_REQ` = pending & `I_FLAG`. It is a combinational AND of two flops, with no input-to-output path.
- `INT_ACK` while `INT_REQ`=0 is illegal. In that case the flop behaviour above still applies, and the bench flags it as an assertion failure.
- Simultaneous `FLG_RESTORE` and `INT_ACK`: ACK wins for C/Z. Shadow takes the pre-edge flags.

## Timing
- Flag latency: command and ALU inputs sampled at edge k; `C_FLAG`/`Z_FLAG`/`I_FLAG` valid after edge k.
- INTR to pending: `INTR` rising before edge k gives pending=1 after edge k+`INTR_SYNC_STAGES`. `INT_REQ` rises in that same cycle if I=1.
- `INT_ACK` at edge k drops `INT_REQ` after edge k. I=0 after edge k, and the shadow is valid after edge k.
- `RST` asserted mid-operation clears all state immediately, without waiting for a clock. First updates occur on the first rising edge after `RST` deasserts.

## Configuration
- Macro: `RAT_FLAG_SHADOW_EN`.
- Defined:
  - Shadow registers are present.
  - `FLG_RESTORE` behaves as specified.
- Undefined:
  - No shadow flops are built.
  - `FLG_RESTORE` is ignored; C/Z follow normal commands.
  - `INT_ACK` still holds C/Z and clears I.

## Structure
- Package `rat_flags_pkg`:
  - `typedef enum logic [1:0] flg_c_op_t {C_HOLD, C_LOAD, C_SET, C_CLR}`.
  - Reset-value constants for C, Z and I.
  - Default `INTR_SYNC_STAGES`.
- Sub-module `rat_intr_latch`:
  - Contains the synchronizer, edge detector and pending flop.
  - Ports: `CLK`, `RST`, `INTR`, `INT_ACK`, `PENDING`.
- The top level holds the C/Z/I/shadow flops and the `INT_REQ` AND.

## Test plan
- Reset: assert `RST` asynchronously mid-cycle with C=Z=I=1 and pending=1 → all outputs 0 before the next `CLK` edge.
- Flag commands:
  - `ALU_C`=1, `ALU_Z`=0, `FLG_C_OP`=01, `FLG_Z_LD`=1 → C=1, Z=0 next cycle.
  - Then `FLG_C_OP`=11 → C=0, Z held.
  - Then `FLG_C_OP`=10 → C=1.
- Interrupt entry/exit:
  - Setup: I=1, C=1, Z=1; pulse `INTR` → `INT_REQ`=1 after 2 synchronizer edges.
  - `INT_ACK` → `INT_REQ`=0, I=0, C/Z hold 1.
  - Load C=0, Z=0.
  - Assert `FLG_RESTORE`+`I_SET` → C=1, Z=1, I=1.
- Masked/held interrupt:
  - Setup: I=0; `INTR` held high 10 cycles → `INT_REQ`=0 and pending=1.
  - Set I → `INT_REQ`=1 next cycle.
  - After `INT_ACK` with `INTR` still high → no second request.
- Coincident edge: a new `INTR` edge detected in the same cycle as `INT_ACK` → pending stays 1; `INT_REQ` reasserts once I is set.
- Macro off: build without `RAT_FLAG_SHADOW_EN`; `FLG_RESTORE` with C=0 → C stays 0.
